jt1943_romarb: RTL and testbench
================================

# jt1943_romarb

Round-robin arbiter that shares one 16-bit SDRAM read port between the six graphics ROM requesters of the 1943 video subsystem: char, scroll1, scroll2, map1, map2, and obj. It sits between the video layer generators and the SDRAM controller. It serialises their fetches, tags each returned word to its owner, and guards against a stalled SDRAM with a watchdog.

## Interface
Parameters
- AW, 22: SDRAM word-address width.
- NCL, 6: number of clients. Fixed index order: 0=char, 1=scr1, 2=scr2, 3=map1, 4=map2, 5=obj.
- TOUT, 255: watchdog limit, in clk cycles, while waiting for sdram_dst.

Ports
- clk, in, 1: system clock. This is the only clock.
- rst_n, in, 1: asynchronous, active-low reset.
- cl_req, in, NCL: level request per client. The client holds it until the matching cl_ok.
- cl_addr, in, NCL*AW: packed client word addresses. Client i uses bits [i*AW +: AW]. Already offset into the global SDRAM map.
- cl_ok, out, NCL: one-cycle pulse. Data for that client is valid on cl_data.
- cl_data, out, 16: registered read data. Holds its value until the next completion.
- sdram_req, out, 1: SDRAM read request. Held until sdram_ack.
- sdram_addr, out, AW: registered address of the granted client.
- sdram_ack, in, 1: controller accepted the request.
- sdram_dst, in, 1: read data strobe.
- sdram_dout, in, 16: read data.
- busy, out, 1: high in any state other than IDLE.
- tout_err, out, 1: sticky flag, set on watchdog expiry.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE
  - Picks the first asserted cl_req, searching from index `ptr` upward, modulo NCL.
  - Latches the winner into `gnt` (3 bits) and its address into sdram_addr.
  - Moves to REQ.
  - With no request pending, stays in IDLE.
- REQ
  - sdram_req=1.
  - On sdram_ack: drops sdram_req, clears the watchdog counter, moves to WAIT.
- WAIT
  - The watchdog counter increments every cycle.
  - On sdram_dst: registers sdram_dout into cl_data and moves to DONE.
  - If the counter reaches TOUT first: sets tout_err, issues no cl_ok, sets `ptr`=gnt+1, returns to IDLE.
- DONE
  - Pulses cl_ok[gnt] for one cycle, but only if cl_req[gnt] is still high. A request that was withdrawn is completed silently and its data discarded.
  - Sets `ptr` to gnt+1, wrapping from 5 to 0.
  - Returns to IDLE.
- `ptr` advances only after a completion or a timeout. This guarantees each requester waits at most NCL−1 foreign transactions.
- sdram_addr is frozen from the IDLE grant through DONE. Changes on cl_addr mid-transaction are ignored.
- Reset values: state=IDLE, ptr=0, gnt=0, sdram_req=0, sdram_addr=0, cl_ok=0, cl_data=0, busy=0, tout_err=0.
- Reset mid-transaction: all state clears immediately. The SDRAM controller is responsible for tolerating the abandoned request.
- sdram_ack and sdram_dst arriving in the same cycle while in REQ: treated as ack followed by data in one step. The FSM goes directly to DONE with the data captured.
- sdram_dst while in IDLE or DONE: ignored.

## Timing
- Request at cycle n seen in IDLE → sdram_req=1 at n+1.
- sdram_ack at cycle a → sdram_req=0 at a+1.
- sdram_dst at cycle d → cl_data valid at d+1 and cl_ok pulse at d+2.
- Minimum turnaround per transaction: 4 cycles, from IDLE back to IDLE. With ack and dst in the same cycle, it is 3 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- JT1943_ROMARB_CACHE_EN defined:
  - Each client has a one-entry cache (tag = last address, value = last data, valid bit; all cleared on reset).
  - In IDLE, the winner is checked against its cache first. On a tag hit it goes straight to DONE: no SDRAM access, cl_ok 2 cycles after the request.
  - Cached entries are updated in DONE.
- Macro undefined: no cache logic. Every grant accesses SDRAM.

## Structure
- Shared package jt1943_romarb_pkg holds:
  - the state enum (IDLE/REQ/WAIT/DONE);
  - client index constants (CL_CHAR…CL_OBJ);
  - the NCL constant.
- Sub-module jt1943_romarb_rr: a combinational round-robin priority encoder. Inputs are req[NCL] and ptr; outputs are the winner index and a valid flag.

## Test plan
- Single request: client 3 raises req at address 0x1A2B3; controller acks after 2 cycles and returns dst with 0xBEEF after 5 → sdram_addr=0x1A2B3, cl_ok[3] pulses once, cl_data=0xBEEF.
- All six requests held together from reset, fixed controller latency → grants in order 0,1,2,3,4,5,0; each cl_ok exactly once per round.
- Client 5 drops req while in WAIT → transaction completes, no cl_ok[5], next grant goes to client 0.
- dst withheld for 256 cycles → tout_err=1, back in IDLE, no cl_ok; the next request is serviced normally.
- rst_n asserted during WAIT → sdram_req, cl_ok, and busy go to 0 immediately; state is IDLE after release.
- With JT1943_ROMARB_CACHE_EN, client 0 repeats address 0x00040 → second access shows no sdram_req, and cl_ok[0] arrives 2 cycles after req with the same data.

Source files
------------

// File: rtl/jt1943_romarb_pkg.sv
// jt1943_romarb_pkg: FSM states, client indices and client count shared by the ROM arbiter
package jt1943_romarb_pkg;
  localparam int NCL     = 6;
  localparam int CL_CHAR = 0;
  localparam int CL_SCR1 = 1;
  localparam int CL_SCR2 = 2;
  localparam int CL_MAP1 = 3;
  localparam int CL_MAP2 = 4;
  localparam int CL_OBJ  = 5;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
endpackage

// File: rtl/jt1943_romarb_rr.sv
// jt1943_romarb_rr: round-robin priority encoder, first request at or after ptr_i wins
module jt1943_romarb_rr #(
  parameter int NCL = jt1943_romarb_pkg::NCL,
  parameter int PW  = $clog2(NCL)
) (
  input  logic [NCL-1:0] req_i,
  input  logic [PW-1:0]  ptr_i,
  output logic [PW-1:0]  win_o,
  output logic           vld_o
);
  int s;
  logic [PW-1:0] idx;
  // scanning from the far end lets the candidate closest to ptr_i overwrite the rest
  always_comb begin
    win_o = '0;
    vld_o = 1'b0;
    s = 0;
    idx = '0;
    for (int k = NCL - 1; k >= 0; k--) begin
      s = int'(ptr_i) + k;
      idx = PW'(s >= NCL ? s - NCL : s);
      if (req_i[idx]) begin
        win_o = idx;
        vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/jt1943_romarb.sv
// jt1943_romarb: round-robin share of one SDRAM read port among the six 1943 graphics ROM clients
// JT1943_ROMARB_CACHE_EN adds a one-entry per-client cache that skips SDRAM on an address hit
module jt1943_romarb #(
  parameter int AW   = 22,
  parameter int NCL  = jt1943_romarb_pkg::NCL,
  parameter int TOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCL-1:0]    cl_req,
  input  logic [NCL*AW-1:0] cl_addr,
  output logic [NCL-1:0]    cl_ok,
  output logic [15:0]       cl_data,
  output logic              sdram_req,
  output logic [AW-1:0]     sdram_addr,
  input  logic              sdram_ack,
  input  logic              sdram_dst,
  input  logic [15:0]       sdram_dout,
  output logic              busy,
  output logic              tout_err
);
  import jt1943_romarb_pkg::*;
  localparam int PW = $clog2(NCL);
  localparam int CW = $clog2(TOUT + 1);
  state_t st_q, st_d;
  logic [PW-1:0] ptr_q, ptr_d, gnt_q, gnt_d, win, nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] addr_arr [NCL];
  logic [NCL-1:0] ok_q, ok_d;
  logic [15:0] data_q, data_d, hit_data;
  logic req_q, req_d, err_q, err_d, vld, hit;
  for (genvar i = 0; i < NCL; i++) assign addr_arr[i] = cl_addr[i*AW +: AW];
  jt1943_romarb_rr #(.NCL(NCL), .PW(PW)) u_rr (
    .req_i(cl_req),
    .ptr_i(ptr_q),
    .win_o(win),
    .vld_o(vld)
  );
  assign nxt = (gnt_q == PW'(NCL - 1)) ? '0 : gnt_q + 1'b1;
`ifdef JT1943_ROMARB_CACHE_EN
  logic [NCL-1:0] cv_q;
  logic [AW-1:0] ctag_q [NCL];
  logic [15:0] cval_q [NCL];
  assign hit = cv_q[win] && ctag_q[win] == addr_arr[win];
  assign hit_data = cval_q[win];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cv_q <= '0;
      for (int k = 0; k < NCL; k++) begin
        ctag_q[k] <= '0;
        cval_q[k] <= '0;
      end
    end else if (st_q == DONE) begin
      cv_q[gnt_q]   <= 1'b1;
      ctag_q[gnt_q] <= addr_q;
      cval_q[gnt_q] <= data_q;
    end
`else
  assign hit = 1'b0;
  assign hit_data = '0;
`endif
  always_comb begin
    st_d = st_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    cnt_d = cnt_q;
    req_d = req_q;
    addr_d = addr_q;
    ok_d = '0;
    data_d = data_q;
    err_d = err_q;
    case (st_q)
      IDLE: if (vld) begin
        gnt_d = win;
        addr_d = addr_arr[win];
        st_d = hit ? DONE : REQ;
        req_d = !hit;
        data_d = hit ? hit_data : data_q;
      end
      // ack and dst together skip WAIT with the data already captured
      REQ: if (sdram_ack) begin
        req_d = 1'b0;
        cnt_d = '0;
        st_d = sdram_dst ? DONE : WAIT;
        data_d = sdram_dst ? sdram_dout : data_q;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (sdram_dst) begin
          data_d = sdram_dout;
          st_d = DONE;
        end else if (cnt_q == CW'(TOUT - 1)) begin
          err_d = 1'b1;
          ptr_d = nxt;
          st_d = IDLE;
        end
      end
      DONE: begin
        ok_d[gnt_q] = cl_req[gnt_q];
        ptr_d = nxt;
        st_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q <= IDLE;
      ptr_q <= '0;
      gnt_q <= '0;
      cnt_q <= '0;
      req_q <= 1'b0;
      addr_q <= '0;
      ok_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      addr_q <= addr_d;
      ok_q <= ok_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  assign cl_ok = ok_q;
  assign cl_data = data_q;
  assign sdram_req = req_q;
  assign sdram_addr = addr_q;
  assign busy = st_q != IDLE;
  assign tout_err = err_q;
endmodule

// File: tb/tb_jt1943_romarb.sv
// tb_jt1943_romarb: directed and randomized bench for jt1943_romarb against a transaction-level model
module tb_jt1943_romarb;
  localparam int AW = 22, NCL = 6, TOUT = 255;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCL-1:0] cl_req = '0;
  logic [NCL-1:0] cl_ok;
  logic [AW-1:0] caddr [NCL];
  logic [NCL*AW-1:0] cl_addr;
  logic [15:0] cl_data;
  logic [15:0] sdram_dout = '0;
  logic sdram_ack = 1'b0, sdram_dst = 1'b0;
  logic sdram_req, busy, tout_err;
  logic [AW-1:0] sdram_addr;
  int checks = 0, errors = 0;
  int ok_cnt [NCL];
  int ok_log [$];
  int exp_order [7] = '{0, 1, 2, 3, 4, 5, 0};
  int ack_lat = -1, dst_lat = -1, ack_cd = -1, dst_cd = -1;
  bit stall = 0, spur = 0, dout_fix = 0;
  logic [15:0] dout_val = '0;
  int m_ptr, m_own, m_wd;
  bit m_act, m_req, m_fin, m_err;
  logic [AW-1:0] m_addr;
  logic [15:0] m_data;
  logic [NCL-1:0] m_ok;
  int b, b2;

  for (genvar g = 0; g < NCL; g++) assign cl_addr[g*AW +: AW] = caddr[g];

  jt1943_romarb dut (
    .clk(clk), .rst_n(rst_n), .cl_req(cl_req), .cl_addr(cl_addr), .cl_ok(cl_ok),
    .cl_data(cl_data), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .sdram_dst(sdram_dst), .sdram_dout(sdram_dout),
    .busy(busy), .tout_err(tout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit cond(input int sel, input int idx);
    case (sel)
      0: return sdram_req;
      1: return cl_ok[idx];
      2: return !busy;
      3: return busy && !sdram_req;
      default: return tout_err;
    endcase
  endfunction

  task automatic wait_until(input string nm, input int sel, input int idx, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cond(sel, idx) && n < budget);
    chk(nm, 32'(cond(sel, idx)), 1);
  endtask

  // Reference: one transaction at a time, winner is the first requester from ptr modulo NCL
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ptr = 0; m_own = 0; m_wd = 0;
      m_act = 0; m_req = 0; m_fin = 0; m_err = 0;
      m_addr = '0; m_data = '0; m_ok = '0;
    end else begin
      m_ok = '0;
      if (!m_act) begin
        for (int k = 0; k < NCL; k++)
          if (!m_act && cl_req[(m_ptr + k) % NCL]) begin
            m_own = (m_ptr + k) % NCL;
            m_act = 1; m_req = 1;
            m_addr = caddr[m_own];
          end
      end else if (m_fin) begin
        m_ok[m_own] = cl_req[m_own];
        m_ptr = (m_own + 1) % NCL;
        m_act = 0; m_fin = 0;
      end else if (m_req) begin
        if (sdram_ack) begin
          m_req = 0; m_wd = 0;
          if (sdram_dst) begin m_data = sdram_dout; m_fin = 1; end
        end
      end else begin
        m_wd++;
        if (sdram_dst) begin m_data = sdram_dout; m_fin = 1; end
        else if (m_wd == TOUT) begin m_err = 1; m_ptr = (m_own + 1) % NCL; m_act = 0; end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    chk("busy", 32'(busy), 32'(m_act));
    chk("sdram_req", 32'(sdram_req), 32'(m_req));
    chk("sdram_addr", 32'(sdram_addr), 32'(m_addr));
    chk("cl_ok", 32'(cl_ok), 32'(m_ok));
    chk("cl_data", 32'(cl_data), 32'(m_data));
    chk("tout_err", 32'(tout_err), 32'(m_err));
    for (int i = 0; i < NCL; i++)
      if (cl_ok[i]) begin
        ok_cnt[i]++;
        ok_log.push_back(i);
      end
  end

  // SDRAM controller: ack after ack_lat cycles of request, dst dst_lat cycles after ack
  initial forever begin
    @(negedge clk);
    sdram_ack = 1'b0;
    sdram_dst = 1'b0;
    sdram_dout = dout_fix ? dout_val : 16'($urandom);
    if (!rst_n) begin
      ack_cd = -1;
      dst_cd = -1;
    end else begin
      if (sdram_req && ack_cd < 0) ack_cd = ack_lat < 0 ? int'($urandom_range(3, 0)) : ack_lat;
      if (ack_cd == 0) begin
        sdram_ack = 1'b1;
        ack_cd = -1;
        if (!stall) dst_cd = dst_lat < 0 ? int'($urandom_range(4, 0)) : dst_lat;
      end else if (ack_cd > 0) ack_cd--;
      if (dst_cd == 0) begin
        sdram_dst = 1'b1;
        dst_cd = -1;
      end else if (dst_cd > 0) dst_cd--;
      else if (spur && !busy && $urandom_range(7, 0) == 0) sdram_dst = 1'b1;
    end
  end

  task automatic rand_clients();
    for (int i = 0; i < NCL; i++)
      if (cl_ok[i]) cl_req[i] = 1'b0;
      else if (!cl_req[i]) begin
        if ($urandom_range(3, 0) == 0) begin
          cl_req[i] = 1'b1;
          caddr[i] = AW'($urandom);
        end
      end else if ($urandom_range(99, 0) == 0) cl_req[i] = 1'b0;
      else if ($urandom_range(49, 0) == 0) caddr[i] = AW'($urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    for (int i = 0; i < NCL; i++) caddr[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sdram_req", 32'(sdram_req), 0);
    chk("rst_sdram_addr", 32'(sdram_addr), 0);
    chk("rst_cl_ok", 32'(cl_ok), 0);
    chk("rst_cl_data", 32'(cl_data), 0);
    chk("rst_tout_err", 32'(tout_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // single request from client 3
    @(negedge clk);
    ack_lat = 2; dst_lat = 3; dout_fix = 1; dout_val = 16'hBEEF;
    caddr[3] = 22'h1A2B3;
    cl_req[3] = 1'b1;
    b = ok_cnt[3];
    wait_until("t1_req", 0, 0, 20);
    chk("t1_addr", 32'(sdram_addr), 32'h1A2B3);
    wait_until("t1_ok", 1, 3, 30);
    cl_req[3] = 1'b0;
    chk("t1_data", 32'(cl_data), 32'hBEEF);
    repeat (5) @(negedge clk);
    chk("t1_ok_once", 32'(ok_cnt[3] - b), 1);
    // all six held from reset
    rst_n = 1'b0;
    cl_req = '1;
    for (int i = 0; i < NCL; i++) caddr[i] = AW'(32'h40 + i * 32'h111);
    ack_lat = 1; dst_lat = 1; dout_fix = 0;
    repeat (2) @(negedge clk);
    ok_log.delete();
    rst_n = 1'b1;
    for (int n = 0; n < 120 && ok_log.size() < 7; n++) @(negedge clk);
    chk("t2_rounds", 32'(ok_log.size() >= 7), 1);
    for (int i = 0; i < 7; i++) chk("t2_order", i < ok_log.size() ? ok_log[i] : -1, exp_order[i]);
    cl_req = '0;
    wait_until("t2_drain", 2, 0, 20);
    // client 5 withdraws while waiting for data
    ack_lat = 0; dst_lat = 4;
    cl_req[5] = 1'b1;
    b = ok_cnt[5];
    wait_until("t3_wait", 3, 0, 20);
    cl_req[5] = 1'b0;
    cl_req[0] = 1'b1;
    cl_req[4] = 1'b1;
    wait_until("t3_req", 0, 0, 20);
    chk("t3_next_gnt", 32'(sdram_addr), 32'h40);
    wait_until("t3_ok0", 1, 0, 20);
    cl_req[0] = 1'b0;
    wait_until("t3_ok4", 1, 4, 30);
    cl_req[4] = 1'b0;
    chk("t3_no_ok5", 32'(ok_cnt[5] - b), 0);
    wait_until("t3_drain", 2, 0, 20);
    // watchdog expiry, then normal service
    stall = 1; ack_lat = 1;
    cl_req[2] = 1'b1;
    b2 = ok_cnt[2];
    wait_until("t4_tout", 4, 0, 300);
    stall = 0; dout_fix = 1; dout_val = 16'h5A5A; dst_lat = 2;
    chk("t4_idle", 32'(busy), 0);
    chk("t4_no_ok", 32'(ok_cnt[2] - b2), 0);
    wait_until("t4_ok", 1, 2, 30);
    cl_req[2] = 1'b0;
    chk("t4_data", 32'(cl_data), 32'h5A5A);
    wait_until("t4_drain", 2, 0, 20);
    // reset in the middle of WAIT
    stall = 1; ack_lat = 0;
    cl_req[1] = 1'b1;
    wait_until("t5_wait", 3, 0, 20);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    cl_req = '0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_sdram_req", 32'(sdram_req), 0);
    chk("t5_cl_ok", 32'(cl_ok), 0);
    chk("t5_tout_err", 32'(tout_err), 0);
    stall = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_idle", 32'(busy), 0);
    // randomized traffic
    ack_lat = -1; dst_lat = -1; dout_fix = 0; spur = 1;
    b = ok_log.size();
    repeat (4000) begin
      @(negedge clk);
      rand_clients();
      stall = ($urandom_range(199, 0) == 0);
    end
    stall = 0;
    cl_req = '0;
    chk("rand_activity", 32'(ok_log.size() > b + 50), 1);
    wait_until("rand_drain", 2, 0, 400);
    spur = 0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
